// File: rtl/display_pkg.sv
// Shared display geometry, pixel packing constants and the frame loader state encoding.
package display_pkg;

  localparam int DISP_WIDTH    = 32;
  localparam int DISP_HEIGHT   = 16;
  localparam int DISP_NPIX     = DISP_WIDTH * DISP_HEIGHT;
  localparam int BYTES_PER_PIX = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RECV      = 2'd1,
    ST_FLIP_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_packer.sv
// Gathers R, G, B bytes into one 24-bit pixel; pixel_valid_o fires combinationally on the blue byte.
module pixel_packer
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid_i,
  input  logic        byte_first_i,
  input  logic [7:0]  byte_data_i,
  output logic [23:0] pixel_o,
  output logic        pixel_valid_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_PIX - 1);

  logic [1:0] byte_cnt_q, byte_cnt_d, byte_idx;
  logic [7:0] red_q, red_d, green_q, green_d;

  // A first byte always lands in the red slot, whatever was left over from before.
  always_comb begin
    byte_idx   = byte_first_i ? 2'd0 : byte_cnt_q;
    byte_cnt_d = byte_cnt_q;
    red_d      = red_q;
    green_d    = green_q;
    if (byte_valid_i) begin
      case (byte_idx)
        2'd0: begin
          red_d      = byte_data_i;
          byte_cnt_d = 2'd1;
        end
        2'd1: begin
          green_d    = byte_data_i;
          byte_cnt_d = 2'd2;
        end
        default: byte_cnt_d = 2'd0;
      endcase
    end
  end

  assign pixel_valid_o = byte_valid_i && (byte_idx == LAST_BYTE);
  assign pixel_o       = {red_q, green_q, byte_data_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q <= 2'd0;
      red_q      <= 8'd0;
      green_q    <= 8'd0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      red_q      <= red_d;
      green_q    <= green_d;
    end
  end

endmodule

// File: rtl/spi_frame_loader.sv
// Streams SPI bytes into the back framebuffer bank as RGB pixels and requests a
// bank flip from scanout once a complete frame has arrived.
module spi_frame_loader
  import display_pkg::*;
#(
  parameter int WIDTH  = DISP_WIDTH,
  parameter int HEIGHT = DISP_HEIGHT,
  parameter int NPIX   = WIDTH * HEIGHT,
  parameter int PIX_W  = $clog2(NPIX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_sot,
  input  logic             in_eot,
  output logic             fb_we,
  output logic [PIX_W:0]   fb_addr,
  output logic [23:0]      fb_wdata,
  output logic             flip_req,
  input  logic             flip_ack,
  output logic             front_buf,
  output logic             err_short,
  output logic             err_long,
  output logic             busy_drop
);

  localparam logic [PIX_W:0] PIX_FULL = (PIX_W + 1)'(NPIX);
  localparam logic [PIX_W:0] PIX_ONE  = (PIX_W + 1)'(1);

  state_e         state_q, state_d;
  logic           eot_q, eot_rise, sot_byte, frame_full;
  logic [PIX_W:0] pix_cnt_q, pix_cnt_d;
  logic           long_seen_q, long_seen_d;
  logic           front_q, front_d;
  logic           fb_we_q, fb_we_d;
  logic [PIX_W:0] fb_addr_q, fb_addr_d;
  logic [23:0]    fb_wdata_q, fb_wdata_d;
  logic           err_short_q, err_short_d;
  logic           err_long_q, err_long_d;
  logic           busy_drop_q, busy_drop_d;
  logic           restart, pk_valid;
  logic [23:0]    pk_pixel;
  logic           pk_pixel_valid;

  assign eot_rise   = in_eot && !eot_q;
  assign sot_byte   = in_valid && in_sot;
  assign frame_full = (pix_cnt_q == PIX_FULL);

  pixel_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .byte_valid_i  (pk_valid),
    .byte_first_i  (restart),
    .byte_data_i   (in_data),
    .pixel_o       (pk_pixel),
    .pixel_valid_o (pk_pixel_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (sot_byte) state_d = ST_RECV;
      ST_RECV: begin
        if (sot_byte)      state_d = ST_RECV;
        else if (eot_rise) state_d = frame_full ? ST_FLIP_WAIT : ST_IDLE;
      end
      ST_FLIP_WAIT: if (flip_ack) state_d = sot_byte ? ST_RECV : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A start byte coinciding with the flip ack is the first byte of the next frame.
  always_comb begin
    restart     = 1'b0;
    pk_valid    = 1'b0;
    long_seen_d = long_seen_q;
    front_d     = front_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    busy_drop_d = 1'b0;
    flip_req    = (state_q == ST_FLIP_WAIT);
    case (state_q)
      ST_IDLE: restart = sot_byte;
      ST_RECV: begin
        if (sot_byte) begin
          restart = 1'b1;
        end else if (eot_rise) begin
          err_short_d = !frame_full;
        end else if (in_valid) begin
          if (frame_full) begin
            err_long_d  = !long_seen_q;
            long_seen_d = 1'b1;
          end else begin
            pk_valid = 1'b1;
          end
        end
      end
      ST_FLIP_WAIT: begin
        if (flip_ack) begin
          front_d = !front_q;
          restart = sot_byte;
        end else begin
          busy_drop_d = sot_byte;
        end
      end
      default: ;
    endcase
    if (restart) begin
      pk_valid    = 1'b1;
      long_seen_d = 1'b0;
    end
  end

  always_comb begin
    pix_cnt_d  = pix_cnt_q;
    fb_we_d    = pk_pixel_valid;
    fb_addr_d  = fb_addr_q;
    fb_wdata_d = fb_wdata_q;
    if (restart) begin
      pix_cnt_d = '0;
    end else if (pk_pixel_valid) begin
      pix_cnt_d  = pix_cnt_q + PIX_ONE;
      fb_addr_d  = {!front_q, pix_cnt_q[PIX_W-1:0]};
      fb_wdata_d = pk_pixel;
    end
  end

  // eot_q starts high so a transfer already in progress at reset cannot fake an end edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      eot_q       <= 1'b1;
      pix_cnt_q   <= '0;
      long_seen_q <= 1'b0;
      front_q     <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      busy_drop_q <= 1'b0;
    end else begin
      eot_q       <= in_eot;
      pix_cnt_q   <= pix_cnt_d;
      long_seen_q <= long_seen_d;
      front_q     <= front_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      busy_drop_q <= busy_drop_d;
    end
  end

  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign front_buf = front_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign busy_drop = busy_drop_q;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: full, short, long and dropped transfers, flip handshake, reset.
module tb_spi_frame_loader;
  import display_pkg::*;

  localparam int NPIX  = DISP_NPIX;
  localparam int PIX_W = $clog2(NPIX);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       in_data = 8'd0;
  logic             in_valid = 1'b0;
  logic             in_sot = 1'b0;
  logic             in_eot = 1'b1;
  logic             flip_ack = 1'b0;
  logic             fb_we;
  logic [PIX_W:0]   fb_addr;
  logic [23:0]      fb_wdata;
  logic             flip_req;
  logic             front_buf;
  logic             err_short;
  logic             err_long;
  logic             busy_drop;

  typedef struct {
    logic [PIX_W:0] addr;
    logic [23:0]    data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_errors = 0;
  int  n_we = 0, n_short = 0, n_long = 0, n_drop = 0;

  spi_frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sot    (in_sot),
    .in_eot    (in_eot),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_wdata  (fb_wdata),
    .flip_req  (flip_req),
    .flip_ack  (flip_ack),
    .front_buf (front_buf),
    .err_short (err_short),
    .err_long  (err_long),
    .busy_drop (busy_drop)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe registered outputs on the falling edge.
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      n_we++;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check_eq("wr_addr", 32'(fb_addr), 32'(mon_e.addr));
        check_eq("wr_data", 32'(fb_wdata), 32'(mon_e.data));
      end
    end
    if (err_short === 1'b1) n_short++;
    if (err_long === 1'b1)  n_long++;
    if (busy_drop === 1'b1) n_drop++;
  end

  task automatic clear_counts();
    n_we = 0; n_short = 0; n_long = 0; n_drop = 0;
  endtask

  // Called at a falling edge; returns one falling edge later.
  task automatic send_byte(input logic [7:0] d, input logic sot);
    in_data  = d;
    in_valid = 1'b1;
    in_sot   = sot;
    @(negedge clk);
    in_valid = 1'b0;
    in_sot   = 1'b0;
    flip_ack = 1'b0;
  endtask

  // Bytes follow R=pixel index, G=g, B=b; expected writes are queued up front.
  task automatic send_frame(input int nbytes, input logic [7:0] g, input logic [7:0] b,
                            input logic bank, input logic with_ack);
    int npw;
    npw = nbytes / 3;
    if (npw > NPIX) npw = NPIX;
    for (int p = 0; p < npw; p++) begin
      wr_t e;
      e.addr = {bank, p[PIX_W-1:0]};
      e.data = {p[7:0], g, b};
      exp_q.push_back(e);
    end
    in_eot = 1'b0;
    if (with_ack) flip_ack = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      int pix;
      int k;
      logic [7:0] d;
      pix = i / 3;
      k   = i % 3;
      d   = (k == 0) ? pix[7:0] : ((k == 1) ? g : b);
      send_byte(d, i == 0);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic end_xfer();
    in_eot = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_ack();
    flip_ack = 1'b1;
    @(negedge clk);
    flip_ack = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_we"},    32'(fb_we), 32'd0);
    check_eq({tag, "_addr"},  32'(fb_addr), 32'd0);
    check_eq({tag, "_wdata"}, 32'(fb_wdata), 32'd0);
    check_eq({tag, "_flip"},  32'(flip_req), 32'd0);
    check_eq({tag, "_front"}, 32'(front_buf), 32'd0);
    check_eq({tag, "_errs"},  32'({err_short, err_long, busy_drop}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    @(negedge clk);
    $display("T0 reset: outputs idle");

    // Full frame into bank 1, then flip.
    clear_counts();
    send_frame(3 * NPIX, 8'h55, 8'hAA, 1'b1, 1'b0);
    check_eq("t1_flip_pre", 32'(flip_req), 32'd0);
    end_xfer();
    check_eq("t1_flip_req", 32'(flip_req), 32'd1);
    check_eq("t1_writes", n_we, NPIX);
    check_eq("t1_q_empty", exp_q.size(), 0);
    check_eq("t1_errs", n_short + n_long + n_drop, 0);
    pulse_ack();
    check_eq("t1_flip_done", 32'(flip_req), 32'd0);
    check_eq("t1_front", 32'(front_buf), 32'd1);
    $display("T1 full frame: writes=%0d front_buf=%0d", n_we, front_buf);

    // Short transfer: 10 bytes, 3 pixels, discarded.
    clear_counts();
    send_frame(10, 8'h12, 8'h34, 1'b0, 1'b0);
    end_xfer();
    repeat (2) @(negedge clk);
    check_eq("t2_writes", n_we, 3);
    check_eq("t2_err_short", n_short, 1);
    check_eq("t2_flip", 32'(flip_req), 32'd0);
    check_eq("t2_front", 32'(front_buf), 32'd1);
    check_eq("t2_q_empty", exp_q.size(), 0);
    $display("T2 short: writes=%0d err_short=%0d", n_we, n_short);

    // Long transfer: 4 surplus bytes, single err_long, flip still requested.
    clear_counts();
    send_frame(3 * NPIX + 4, 8'h33, 8'hCC, 1'b0, 1'b0);
    end_xfer();
    check_eq("t3_flip_req", 32'(flip_req), 32'd1);
    check_eq("t3_writes", n_we, NPIX);
    check_eq("t3_err_long", n_long, 1);
    check_eq("t3_err_short", n_short, 0);
    check_eq("t3_q_empty", exp_q.size(), 0);
    $display("T3 long: writes=%0d err_long=%0d", n_we, n_long);

    // New transfer while flip pending, no ack: dropped.
    clear_counts();
    in_eot = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1), i == 0);
    repeat (2) @(negedge clk);
    end_xfer();
    repeat (2) @(negedge clk);
    check_eq("t4_busy_drop", n_drop, 1);
    check_eq("t4_writes", n_we, 0);
    check_eq("t4_flip_held", 32'(flip_req), 32'd1);
    pulse_ack();
    check_eq("t4_flip_done", 32'(flip_req), 32'd0);
    check_eq("t4_front", 32'(front_buf), 32'd0);
    $display("T4 busy: busy_drop=%0d writes=%0d front_buf=%0d", n_drop, n_we, front_buf);

    // Ack coincident with the start byte of the next transfer.
    clear_counts();
    send_frame(3 * NPIX, 8'h5A, 8'hA5, 1'b1, 1'b0);
    end_xfer();
    check_eq("t5_flip_req", 32'(flip_req), 32'd1);
    check_eq("t5_writes_a", n_we, NPIX);
    clear_counts();
    send_frame(6, 8'h77, 8'h88, 1'b0, 1'b1);
    check_eq("t5_front", 32'(front_buf), 32'd1);
    check_eq("t5_flip_done", 32'(flip_req), 32'd0);
    check_eq("t5_writes_b", n_we, 2);
    check_eq("t5_no_drop", n_drop, 0);
    check_eq("t5_q_empty", exp_q.size(), 0);
    end_xfer();
    repeat (2) @(negedge clk);
    check_eq("t5_err_short", n_short, 1);
    $display("T5 ack+sot: front_buf=%0d writes=%0d", front_buf, n_we);

    // Reset after 100 bytes, then a clean frame from pixel 0 into bank 1.
    clear_counts();
    send_frame(100, 8'h11, 8'h22, 1'b0, 1'b0);
    check_eq("t6_writes_a", n_we, 33);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("t6_rst");
    in_eot = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    clear_counts();
    send_frame(3 * NPIX, 8'h55, 8'hAA, 1'b1, 1'b0);
    end_xfer();
    check_eq("t6_flip_req", 32'(flip_req), 32'd1);
    check_eq("t6_writes_b", n_we, NPIX);
    check_eq("t6_q_empty", exp_q.size(), 0);
    pulse_ack();
    check_eq("t6_front", 32'(front_buf), 32'd1);
    $display("T6 reset: writes=%0d front_buf=%0d", n_we, front_buf);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_frame_loader.md
# spi_frame_loader

Sequences the byte stream from the SPI slave receiver into the display framebuffer. Packs three bytes per pixel (R, G, B), generates framebuffer write addresses into the current back buffer, and on a complete transfer requests a buffer flip from the scanout logic. Sits between the SPI slave and the dual-bank framebuffer RAM / scanout in the display controller.

## Interface
- `WIDTH`, 32, display columns
- `HEIGHT`, 16, display rows
- `NPIX`, WIDTH*HEIGHT, pixels per frame (derived)
- `PIX_W`, $clog2(NPIX), pixel index width (derived)
- `clk` in 1, system clock
- `rst` in 1, synchronous, active-high reset
- `in_data` in 8, received byte, valid only when `in_valid`=1
- `in_valid` in 1, one-cycle pulse per received byte
- `in_sot` in 1, asserted together with `in_valid` on the first byte of a transfer
- `in_eot` in 1, level, high while slave select is deasserted
- `fb_we` in/out: out 1, framebuffer write strobe, one cycle per pixel
- `fb_addr` out PIX_W+1, {bank, pixel index}
- `fb_wdata` out 24, {R,G,B}
- `flip_req` out 1, held high until acknowledged
- `flip_ack` in 1, one-cycle pulse from scanout at vblank
- `front_buf` out 1, bank currently scanned out
- `err_short` out 1, pulse: transfer ended before NPIX pixels
- `err_long` out 1, pulse: bytes beyond 3*NPIX received
- `busy_drop` out 1, pulse: transfer started while flip pending, dropped

## Operation
- States: IDLE, RECV, FLIP_WAIT.
- IDLE: `in_valid`&`in_sot` -> RECV; byte counted as R of pixel 0. `in_valid` without `in_sot` ignored.
- RECV: each `in_valid` advances byte_cnt 0→1→2→0. byte 0 → wdata[23:16], 1 → [15:8], 2 → [7:0]. On byte 2: `fb_we`=1, `fb_addr`={~front_buf, pix_cnt}, pix_cnt++.
- Bytes after pixel NPIX-1 written: discarded, no write; one `err_long` pulse on the first such byte per transfer.
- `in_sot`&`in_valid` in RECV: restart at pixel 0 byte 0 (no flip, no error).
- Rising edge of `in_eot` in RECV: if pix_cnt==NPIX (all pixels written) -> FLIP_WAIT, `flip_req`=1; else `err_short` pulse, -> IDLE, partial pixel and frame discarded, banks unchanged.
- FLIP_WAIT: `flip_ack` -> `front_buf` toggles, `flip_req`=0, -> IDLE. `in_sot`&`in_valid` without ack -> `busy_drop` pulse, rest of that transfer ignored.
- Simultaneous `flip_ack` and `in_sot`&`in_valid` in FLIP_WAIT: flip completes and the byte is accepted as pixel 0 byte 0 into the new back bank (-> RECV); no `busy_drop`.
- `in_eot` edge detect uses a registered copy of `in_eot`, reset to 1.

## Timing
- Reset values: `fb_we`=0, `fb_addr`=0, `fb_wdata`=0, `flip_req`=0, `front_buf`=0, all error pulses 0, state IDLE, counters 0.
- Write latency: `fb_we` registered, asserted the cycle after the `in_valid` of byte 2; address/data stable in that cycle only.
- `flip_req` rises the cycle after the `in_eot` rising edge; falls the cycle after `flip_ack`; `front_buf` toggles in the same cycle.
- Error pulses exactly one cycle, registered.
- Reset mid-transfer or mid-flip: immediate return to reset values; pending flip abandoned, `front_buf` back to 0.
- Back-to-back `in_valid` on consecutive cycles supported.

## Structure
- Package `display_pkg`: WIDTH/HEIGHT/NPIX defaults, bytes-per-pixel constant (3), state enum.
- Sub-module `pixel_packer`: byte_cnt and 24-bit shift/assembly, outputs pixel + pixel_valid; FSM, address counter and flip handshake stay in top.

## Test plan
- Full frame 3*NPIX bytes, R=pixel index, G=0x55, B=0xAA, then eot -> NPIX writes to bank 1, addr {1,i}, data {i[7:0],55,AA}; `flip_req`; ack -> `front_buf`=1.
- Transfer of 10 bytes then eot -> 3 writes, `err_short` one pulse, no `flip_req`, `front_buf` unchanged.
- 3*NPIX+4 bytes -> NPIX writes, one `err_long` pulse, flip still requested.
- Second transfer sot while `flip_req` held, no ack -> `busy_drop` pulse, zero writes; then ack -> IDLE.
- `flip_ack` coincident with sot byte -> `front_buf` toggles, subsequent writes go to new back bank starting pixel 0.
- `rst` asserted mid-frame after 100 bytes -> all outputs reset next cycle; next full frame writes bank 1 from pixel 0.
